// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen
//   Stimulus source and run controller for the Booth multiplier BIST.
//   An 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1, the MISR polynomial) drives the
//   CUT: pattern[3:0] is operand A, pattern[7:4] is operand B. The block
//   clears the MISR, enables it in step with the CUT latency and, once all
//   responses are compacted, compares the signature against GOLDEN.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        single-cycle run request, honoured only in IDLE or DONE
//   signature    MISR q output
//   pattern      registered LFSR state, stimulus to the CUT
//   misr_shift   registered MISR shift enable
//   misr_reset_b registered active-low clear to the MISR async reset
//   busy         high in CLEAR, RUN, FLUSH and COMPARE
//   done         high in DONE
//   pass         result of the last compare, valid while done=1
module bist_pattern_gen #(
    parameter logic [7:0] SEED         = 8'h01,
    parameter int         NUM_PATTERNS = 255,
    parameter int         CUT_LATENCY  = 1,
    parameter logic [7:0] GOLDEN       = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] signature,
    output logic [7:0] pattern,
    output logic       misr_shift,
    output logic       misr_reset_b,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // The counter is shared: it counts patterns in RUN and flush cycles in FLUSH.
    localparam logic [15:0] LAST_PAT   = 16'(NUM_PATTERNS - 1);
    localparam logic [15:0] LAST_FLUSH = 16'(CUT_LATENCY - 1);

    state_t                 state;
    state_t                 next_state;
    logic [15:0]            count;
    logic [CUT_LATENCY-1:0] shift_dl;

    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        lfsr_next = {p[6], p[5], p[4], p[3] ^ p[7], p[2] ^ p[7], p[1] ^ p[7], p[0], p[7]};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = RUN;
            RUN:     if (count == LAST_PAT) next_state = FLUSH;
            FLUSH:   if (count == LAST_FLUSH) next_state = COMPARE;
            COMPARE: next_state = DONE;
            DONE:    if (start) next_state = CLEAR;
            default: next_state = IDLE;
        endcase
    end

    assign busy       = (state == CLEAR) || (state == RUN) || (state == FLUSH) || (state == COMPARE);
    assign done       = (state == DONE);
    // The oldest delay-line tap is a flop, so the shift enable stays registered.
    assign misr_shift = shift_dl[CUT_LATENCY-1];

    // NOTE: the shift delay line is reset along with the control flops because
    // misr_shift must be provably low out of reset; it is control, not data storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern      <= SEED;
            misr_reset_b <= 1'b0;
            pass         <= 1'b0;
            count        <= '0;
            shift_dl     <= '0;
        end else begin
            // Decoded from next_state so the MISR clear is low for exactly the
            // CLEAR cycle and comes straight from a flop (no decode glitches).
            misr_reset_b <= (next_state != CLEAR);

            if (state == CLEAR) begin
                shift_dl <= '0;
            end else begin
                shift_dl[0] <= (state == RUN);
                for (int i = 1; i < CUT_LATENCY; i++) begin
                    shift_dl[i] <= shift_dl[i-1];
                end
            end

            unique case (state)
                CLEAR: begin
                    pattern <= SEED;
                    count   <= '0;
                end
                RUN: begin
                    pattern <= lfsr_next(pattern);
                    count   <= (count == LAST_PAT) ? 16'd0 : count + 16'd1;
                end
                FLUSH: begin
                    count <= count + 16'd1;
                end
                COMPARE: begin
                    pass <= (signature == GOLDEN);
                end
                default: begin
                end
            endcase

            // A new run wipes the previous verdict as CLEAR is entered.
            if (next_state == CLEAR) begin
                pass <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// tb_bist_pattern_gen
//   Three instances: A (N=10, L=1) is checked cycle by cycle from a table;
//   B and C (N=255, L=2) run against a bench MISR fed by a 2-cycle CUT
//   register, with GOLDEN computed by a GF(2^8) model (C's is off by one bit).
module tb_bist_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, start_b, start_c;
    logic [7:0] sig_a;

    logic [7:0] pattern_a, pattern_b, pattern_c;
    logic       shift_a, shift_b, shift_c;
    logic       rstb_a, rstb_b, rstb_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       pass_a, pass_b, pass_c;
    logic [7:0] misr_b, misr_c;

    int errors = 0;
    int checks = 0;

    // Multiply by x modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] mulx(input logic [7:0] v);
        logic [8:0] w;
        w = {v, 1'b0};
        if (w[8]) w = w ^ 9'h11D;
        return w[7:0];
    endfunction

    // Patterns are SEED*x^k; the MISR folds them as s = s*x + d.
    function automatic logic [7:0] model_golden(input int n);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h01;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = mulx(s) ^ p;
            p = mulx(p);
        end
        return s;
    endfunction

    localparam logic [7:0] GOLD_B = model_golden(255);

    bist_pattern_gen #(.SEED(8'h01), .NUM_PATTERNS(10), .CUT_LATENCY(1), .GOLDEN(8'h00)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .signature(sig_a),
        .pattern(pattern_a), .misr_shift(shift_a), .misr_reset_b(rstb_a),
        .busy(busy_a), .done(done_a), .pass(pass_a));

    bist_pattern_gen #(.SEED(8'h01), .NUM_PATTERNS(255), .CUT_LATENCY(2), .GOLDEN(GOLD_B)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .signature(misr_b),
        .pattern(pattern_b), .misr_shift(shift_b), .misr_reset_b(rstb_b),
        .busy(busy_b), .done(done_b), .pass(pass_b));

    bist_pattern_gen #(.SEED(8'h01), .NUM_PATTERNS(255), .CUT_LATENCY(2), .GOLDEN(GOLD_B ^ 8'h01)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .signature(misr_c),
        .pattern(pattern_c), .misr_shift(shift_c), .misr_reset_b(rstb_c),
        .busy(busy_c), .done(done_c), .pass(pass_c));

    // CUT stand-in (2-cycle register of pattern) and MISR for B and C.
    logic [7:0] cut_b1, cut_b2, cut_c1, cut_c2;
    always_ff @(posedge clk) begin
        cut_b1 <= pattern_b;
        cut_b2 <= cut_b1;
        cut_c1 <= pattern_c;
        cut_c2 <= cut_c1;
    end
    always_ff @(posedge clk or negedge rstb_b) begin
        if (!rstb_b) misr_b <= 8'h00;
        else if (shift_b) misr_b <= mulx(misr_b) ^ cut_b2;
    end
    always_ff @(posedge clk or negedge rstb_c) begin
        if (!rstb_c) misr_c <= 8'h00;
        else if (shift_c) misr_c <= mulx(misr_c) ^ cut_c2;
    end

    typedef struct {
        logic       chk_pat;
        logic [7:0] pat;
        logic       shift;
        logic       rstb;
        logic       busy;
        logic       done;
        logic       pass_live;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run of A, compared row by row; noise_c pulses start while busy.
    task automatic run_table(input logic [7:0] sig, input int noise_c);
        int   shifts;
        logic exp_pass;
        shifts   = 0;
        exp_pass = (sig == 8'h00);
        sig_a    = sig;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) begin
                tick();
                start_a = 1'b0;
            end
            if (tbl[c].chk_pat) check($sformatf("c%0d pattern", c), pattern_a, tbl[c].pat);
            check($sformatf("c%0d misr_shift", c), shift_a, tbl[c].shift);
            check($sformatf("c%0d misr_reset_b", c), rstb_a, tbl[c].rstb);
            check($sformatf("c%0d busy", c), busy_a, tbl[c].busy);
            check($sformatf("c%0d done", c), done_a, tbl[c].done);
            check($sformatf("c%0d pass", c), pass_a, tbl[c].pass_live ? exp_pass : 1'b0);
            shifts += int'(shift_a);
            if (c == noise_c) start_a = 1'b1;
        end
        start_a = 1'b0;
        check("A shift count", shifts, 10);
    endtask

    // Full-period run of B and C together, with a stray start on the 5th RUN cycle.
    task automatic run_long(input string tag);
        int seen[256];
        int busy_cnt, sh_b, sh_c, done_at, uniq;
        foreach (seen[v]) seen[v] = 0;
        busy_cnt = 0;
        sh_b     = 0;
        sh_c     = 0;
        done_at  = -1;
        start_b  = 1'b1;
        start_c  = 1'b1;
        tick();
        start_b  = 1'b0;
        start_c  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                tick();
                start_b = 1'b0;
            end
            if (done_b && done_c) begin
                done_at = c;
                break;
            end
            busy_cnt += int'(busy_b);
            sh_b     += int'(shift_b);
            sh_c     += int'(shift_c);
            if (c >= 1 && c <= 255) seen[pattern_b]++;
            if (c == 5) start_b = 1'b1;
        end
        uniq = 0;
        for (int v = 1; v < 256; v++) if (seen[v] == 1) uniq++;
        check({tag, " done cycle"}, done_at, 259);
        check({tag, " busy cycles"}, busy_cnt, 259);
        check({tag, " B shift count"}, sh_b, 255);
        check({tag, " C shift count"}, sh_c, 255);
        check({tag, " distinct nonzero patterns"}, uniq, 255);
        check({tag, " zero pattern seen"}, seen[0], 0);
        check({tag, " B signature"}, misr_b, GOLD_B);
        check({tag, " B pass"}, pass_b, 1'b1);
        check({tag, " C pass"}, pass_c, 1'b0);
        check({tag, " B pattern after run"}, pattern_b, 8'h01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq[11];
        logic [7:0] rsig;
        int         rnoise;

        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74};
        for (int c = 0; c < 15; c++) begin
            tbl[c].chk_pat   = (c != 0);
            tbl[c].pat       = seq[(c == 0) ? 0 : ((c >= 11) ? 10 : c - 1)];
            tbl[c].shift     = (c >= 2) && (c <= 11);
            tbl[c].rstb      = (c != 0);
            tbl[c].busy      = (c <= 12);
            tbl[c].done      = (c >= 13);
            tbl[c].pass_live = (c >= 13);
        end

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        sig_a   = 8'h00;
        #1;
        check("reset pattern", pattern_a, 8'h01);
        check("reset misr_shift", shift_a, 1'b0);
        check("reset misr_reset_b", rstb_a, 1'b0);
        check("reset busy", busy_a, 1'b0);
        check("reset done", done_a, 1'b0);
        check("reset pass", pass_a, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("idle misr_reset_b", rstb_a, 1'b1);
        check("idle busy", busy_a, 1'b0);
        check("idle pattern", pattern_a, 8'h01);

        run_table(8'h00, -1);
        run_table(8'h55, 5);
        run_table(8'h00, -1);

        // Reset on the 4th RUN cycle of A.
        sig_a   = 8'h00;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("pre-reset pattern", pattern_a, 8'h08);
        check("pre-reset misr_shift", shift_a, 1'b1);
        reset = 1'b1;
        #1;
        check("mid reset pattern", pattern_a, 8'h01);
        check("mid reset misr_shift", shift_a, 1'b0);
        check("mid reset busy", busy_a, 1'b0);
        check("mid reset misr_reset_b", rstb_a, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no restart busy %0d", i), busy_a, 1'b0);
            check($sformatf("no restart shift %0d", i), shift_a, 1'b0);
        end
        run_table(8'h00, -1);

        for (int r = 0; r < 4; r++) begin
            rsig   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rnoise = int'($urandom_range(1, 12));
            run_table(rsig, rnoise);
        end

        run_long("run1");
        run_long("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
